// File: rtl/free_list_ckpt.sv
// N-way physical-register free list with a single branch checkpoint on the head pointer.
// Tags are popped from head for rename and pushed at tail on retirement.
module free_list_ckpt #(
    parameter int unsigned N_WAY      = 3,
    parameter int unsigned N_PHYS_REG = 64,
    parameter int unsigned N_ARCH_REG = 32,
    parameter int unsigned TAG_W      = $clog2(N_PHYS_REG)
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [$clog2(N_WAY):0]                    dispatch_num,
    input  logic [N_WAY-1:0]                          retire_valid,
    input  logic [N_WAY*TAG_W-1:0]                    rob_told,
    input  logic                                      ckpt_save,
    input  logic                                      ckpt_restore,
    output logic [N_WAY*TAG_W-1:0]                    free_list_out,
    output logic [$clog2(N_WAY):0]                    free_num,
    output logic [$clog2(N_PHYS_REG-N_ARCH_REG):0]    free_count,
    output logic                                      overflow_err
);

    localparam int unsigned DEPTH = N_PHYS_REG - N_ARCH_REG;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned NUM_W = $clog2(N_WAY) + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   sum_t;
    typedef logic [NUM_W-1:0] num_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Pointer = {wrap, index}; index stays in [0, DEPTH) so DEPTH need not be a power of 2.
    function automatic ptr_t ptr_add(input ptr_t p, input cnt_t k);
        sum_t s;
        ptr_t r;
        s = sum_t'(p[IDX_W-1:0]) + sum_t'(k);
        if (s >= sum_t'(DEPTH)) begin
            r = {~p[IDX_W], idx_t'(s - sum_t'(DEPTH))};
        end else begin
            r = {p[IDX_W], idx_t'(s)};
        end
        return r;
    endfunction

    function automatic cnt_t ptr_dist(input ptr_t from, input ptr_t to);
        cnt_t d;
        if (from[IDX_W] == to[IDX_W]) begin
            d = cnt_t'(to[IDX_W-1:0]) - cnt_t'(from[IDX_W-1:0]);
        end else begin
            d = cnt_t'(DEPTH) - cnt_t'(from[IDX_W-1:0]) + cnt_t'(to[IDX_W-1:0]);
        end
        return d;
    endfunction

    tag_t entries_q [DEPTH];
    ptr_t head_q, tail_q, snap_q;
    logic ovf_q;

    cnt_t             count;
    num_t             num;
    num_t             alloc;
    ptr_t             head_alloc;
    cnt_t             used;
    cnt_t             room;
    cnt_t             n_wr;
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             ovf_hit;
    logic [N_WAY-1:0] wr_en;
    idx_t             wr_idx [N_WAY];
    ptr_t             head_d, tail_d, snap_d;

    always_comb begin
        count      = ptr_dist(head_q, tail_q);
        num        = (count >= cnt_t'(N_WAY)) ? num_t'(N_WAY) : num_t'(count);
        // A restore flushes the front end, so this cycle's dispatch request is dropped.
        alloc      = ckpt_restore ? '0 : ((dispatch_num > num) ? num : dispatch_num);
        head_alloc = ptr_add(head_q, cnt_t'(alloc));
        used       = ckpt_restore ? ptr_dist(snap_q, tail_q) : (count - cnt_t'(alloc));
        room       = cnt_t'(DEPTH) - used;

        n_wr    = '0;
        ovf_hit = 1'b0;
        wr_en   = '0;
        wr_ptr  = tail_q;
        for (int i = 0; i < N_WAY; i++) begin
            wr_idx[i] = '0;
            wr_ptr    = ptr_add(tail_q, n_wr);
            if (retire_valid[i]) begin
                if (n_wr < room) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = wr_ptr[IDX_W-1:0];
                    n_wr      = n_wr + cnt_t'(1);
                end else begin
                    ovf_hit = 1'b1;
                end
            end
        end

        tail_d = ptr_add(tail_q, n_wr);
        head_d = ckpt_restore ? snap_q : head_alloc;
        snap_d = (ckpt_save && !ckpt_restore) ? head_alloc : snap_q;
    end

    always_comb begin
        free_list_out = '0;
        rd_ptr        = head_q;
        for (int i = 0; i < N_WAY; i++) begin
            rd_ptr = ptr_add(head_q, cnt_t'(i));
            if (num_t'(i) < num) begin
                free_list_out[i*TAG_W +: TAG_W] = entries_q[rd_ptr[IDX_W-1:0]];
            end
        end
    end

    assign free_count   = count;
    assign free_num     = num;
    assign overflow_err = ovf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_q[k] <= tag_t'(N_ARCH_REG + k);
            end
            head_q <= '0;
            tail_q <= {1'b1, idx_t'(0)};
            snap_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_WAY; i++) begin
                if (wr_en[i]) begin
                    entries_q[wr_idx[i]] <= rob_told[i*TAG_W +: TAG_W];
                end
            end
            head_q <= head_d;
            tail_q <= tail_d;
            snap_q <= snap_d;
            ovf_q  <= ovf_q | ovf_hit;
        end
    end

endmodule
